// File: rtl/oam_dma.sv
// OAM DMA engine: copies NBYTES bytes from {page,00} on the source bus to OAM at FE00.
// Optional OAM_DMA_ECHO_MIRROR_EN remaps latched pages E0-FF down to C0-DF.
module oam_dma #(
  parameter int READ_LAT = 2,
  parameter int NBYTES   = 160
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  dma_page,
  output logic [15:0] A_src,
  input  logic [7:0]  Di_src,
  output logic        rd_src,
  output logic [15:0] A_oam,
  output logic [7:0]  Do_oam,
  output logic        wr_oam,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  state_t      state, state_n;
  logic [7:0]  page, page_n, idx, idx_n, page_eff;
  logic [2:0]  cnt, cnt_n;
  logic [15:0] a_src_n, a_oam_n;
  logic [7:0]  do_n;
  logic        rd_n, wr_n, busy_n, done_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      page   <= '0;
      idx    <= '0;
      cnt    <= '0;
      A_src  <= '0;
      rd_src <= 1'b0;
      A_oam  <= '0;
      Do_oam <= '0;
      wr_oam <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      page   <= page_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      A_src  <= a_src_n;
      rd_src <= rd_n;
      A_oam  <= a_oam_n;
      Do_oam <= do_n;
      wr_oam <= wr_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Outputs are registered: each branch sets the output values for the state being entered.
  always_comb begin
    state_n  = state;
    page_n   = page;
    idx_n    = idx;
    cnt_n    = cnt;
    a_src_n  = A_src;
    rd_n     = rd_src;
    a_oam_n  = A_oam;
    do_n     = Do_oam;
    wr_n     = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    page_eff = dma_page;
`ifdef OAM_DMA_ECHO_MIRROR_EN
    if (dma_page >= 8'hE0) page_eff = dma_page - 8'h20;
`endif
    // A pulse starts from IDLE or aborts any running transfer without a done pulse.
    if (dma_page != 8'h00) begin
      state_n = READ;
      page_n  = page_eff;
      idx_n   = 8'h00;
      a_src_n = {page_eff, 8'h00};
      rd_n    = 1'b1;
      busy_n  = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        READ: begin
          state_n = WAIT;
          cnt_n   = 3'(READ_LAT - 1);
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state_n = WRITE;
            do_n    = Di_src;
            rd_n    = 1'b0;
            wr_n    = 1'b1;
            a_oam_n = 16'hFE00 + {8'h00, idx};
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end
        WRITE: begin
          if (idx == 8'(NBYTES - 1)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = READ;
            idx_n   = idx + 8'd1;
            a_src_n = {page, idx + 8'd1};
            rd_n    = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected OAM writes, a monitor pops and compares.
module tb_oam_dma;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  dma_page = 8'h00;
  logic [15:0] A_src, A_oam;
  logic [7:0]  Di_src = 8'h00, Do_oam, s1 = 8'h00;
  logic        rd_src, wr_oam, busy, done;

  int errors = 0, checks = 0;
  logic [23:0] exp_q[$];
  int cyc = 0, last_cyc = 0, done_total = 0;
  logic [7:0] last_idx = 8'h00;
  bit have_last = 0, overlap = 0, zp_active = 0, zp_bad = 0;

  oam_dma #(.READ_LAT(2), .NBYTES(160)) dut (
    .clock(clock), .reset_n(reset_n), .dma_page(dma_page),
    .A_src(A_src), .Di_src(Di_src), .rd_src(rd_src),
    .A_oam(A_oam), .Do_oam(Do_oam), .wr_oam(wr_oam),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Source bus: data for an address appears two cycles after it is presented.
  always @(posedge clock) begin
    s1     <= A_src[7:0] ^ 8'h5A;
    Di_src <= s1;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic push_writes(int n);
    for (int k = 0; k < n; k++) exp_q.push_back({16'hFE00 + 16'(k), 8'(k) ^ 8'h5A});
  endtask

  task automatic pulse(logic [7:0] p);
    @(posedge clock); #1 dma_page = p;
    @(posedge clock); #1 dma_page = 8'h00;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clock); n++; end
    if (busy) chk({name, "_timeout"}, 1, 0);
  endtask

  always @(negedge clock) begin
    cyc++;
    if (rd_src && wr_oam) overlap = 1;
    if (zp_active && (busy || rd_src || wr_oam || done)) zp_bad = 1;
    if (done) begin
      done_total++;
      chk("busy_low_at_done", busy, 0);
    end
    if (wr_oam) begin
      if (exp_q.size() == 0) chk("unexpected_write", {A_oam, Do_oam}, 0);
      else chk("oam_write", {A_oam, Do_oam}, exp_q.pop_front());
      if (have_last && A_oam[7:0] == last_idx + 8'd1) chk("write_spacing", cyc - last_cyc, 4);
      have_last = 1;
      last_idx  = A_oam[7:0];
      last_cyc  = cyc;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1 chk("reset_outputs", {A_src, rd_src, A_oam, Do_oam, wr_oam, busy, done}, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);

    // Full transfer from C100
    push_writes(160);
    pulse(8'hC1);
    chk("start_busy_rd", {busy, rd_src}, 2'b11);
    chk("start_addr", A_src, 16'hC100);
    n = 0;
    do begin @(negedge clock); if (busy) n++; end while (busy && n < 2000);
    chk("busy_cycles", n, 640);
    repeat (3) @(negedge clock);
    chk("done_count_1", done_total, 1);
    chk("queue_empty_1", exp_q.size(), 0);

    // Zero page idles
    zp_active = 1;
    repeat (1000) @(negedge clock);
    zp_active = 0;
    chk("zero_page_idle", zp_bad, 0);

    // Restart 100 cycles into a transfer
    push_writes(25);
    pulse(8'hC0);
    repeat (99) @(posedge clock);
    #1 dma_page = 8'hD0;
    @(posedge clock); #1 dma_page = 8'h00;
    chk("restart_addr", A_src, 16'hD000);
    chk("restart_busy_rd", {busy, rd_src}, 2'b11);
    chk("restart_no_done", done_total, 1);
    push_writes(160);
    wait_idle("restart");
    repeat (3) @(negedge clock);
    chk("done_count_2", done_total, 2);
    chk("queue_empty_2", exp_q.size(), 0);

    // Async reset during byte 37 WAIT
    push_writes(37);
    pulse(8'hC1);
    n = 0;
    while (!(rd_src && A_src == 16'hC125) && n < 1000) begin @(negedge clock); n++; end
    chk("reached_byte37", A_src, 16'hC125);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1 chk("async_reset_outputs", {A_src, rd_src, A_oam, Do_oam, wr_oam, busy, done}, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (50) @(negedge clock);
    chk("idle_after_reset", {busy, rd_src, A_src}, 0);
    chk("queue_empty_3", exp_q.size(), 0);
    chk("done_count_3", done_total, 2);

    // Echo mirror
    push_writes(160);
    pulse(8'hE3);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    chk("mirror_addr", A_src, 16'hC300);
`else
    chk("mirror_addr", A_src, 16'hE300);
`endif
    wait_idle("mirror");
    repeat (3) @(negedge clock);
    chk("done_count_4", done_total, 3);
    chk("queue_empty_4", exp_q.size(), 0);
    chk("rd_wr_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
